mmio_fifo_csr: RTL

Parametrised MMIO-mapped FIFO register block for the CCI-P AFU.
- Host MMIO writes push data; host MMIO reads pop or peek data, read status, and write control.
- Adds configurable width and depth, full/empty/count status, sticky overflow/underflow flags, flush, and peek.
- Sits beside the AFU's MMIO decode. The AFU top level feeds it unpacked MMIO header fields and muxes its read response into tx.c2.

---
 rtl/mmio_fifo_pkg.sv | 31 +++
 rtl/mmio_fifo_csr_if.sv | 23 ++
 rtl/sync_fifo_core.sv | 59 +++++
 rtl/mmio_fifo_csr.sv | 112 +++++++++++
 4 files changed

// File: rtl/mmio_fifo_pkg.sv
// Shared register map, status layout and control bit positions for the MMIO FIFO CSR block.
package mmio_fifo_pkg;

  localparam int unsigned REG_DATA   = 0;
  localparam int unsigned REG_STATUS = 2;
  localparam int unsigned REG_CTRL   = 4;
  localparam int unsigned REG_PEEK   = 6;

  localparam int unsigned STAT_COUNT_LSB = 0;
  localparam int unsigned STAT_EMPTY_BIT = 16;
  localparam int unsigned STAT_FULL_BIT  = 17;
  localparam int unsigned STAT_OVF_BIT   = 18;
  localparam int unsigned STAT_UNF_BIT   = 19;
  localparam int unsigned STAT_DEPTH_LSB = 32;

  localparam int unsigned CTRL_FLUSH_BIT     = 0;
  localparam int unsigned CTRL_CLR_FLAGS_BIT = 1;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [15:0] depth;
    logic [11:0] rsvd_mid;
    logic        underflow;
    logic        overflow;
    logic        full;
    logic        empty;
    logic [15:0] count;
  } t_mmio_fifo_status;

endpackage

// File: rtl/mmio_fifo_csr_if.sv
// MMIO request/response bundle between the AFU decode (master) and the FIFO CSR block (slave).
interface mmio_fifo_csr_if #(
  parameter int ADDR_W = 16
);
  logic              mmio_wr_valid;
  logic              mmio_rd_valid;
  logic [ADDR_W-1:0] mmio_addr;
  logic [8:0]        mmio_tid;
  logic [63:0]       mmio_wr_data;
  logic              rd_resp_valid;
  logic [8:0]        rd_resp_tid;
  logic [63:0]       rd_resp_data;

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data,
    input  rd_resp_valid, rd_resp_tid, rd_resp_data
  );

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data,
    output rd_resp_valid, rd_resp_tid, rd_resp_data
  );
endinterface

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO storage with explicit-wrap pointers so any DEPTH (not just powers of two) works.
module sync_fifo_core #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mmio_fifo_csr.sv
// MMIO-mapped FIFO: decodes DATA/STATUS/CTRL/PEEK, keeps sticky error flags, returns reads one cycle later.
module mmio_fifo_csr
  import mmio_fifo_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          DEPTH     = 8,
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 32'h0020
) (
  input  logic                       clk,
  input  logic                       rst,
  mmio_fifo_csr_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  logic              hit_data;
  logic              hit_status;
  logic              hit_ctrl;
  logic              hit_peek;
  logic              any_hit;
  logic              push;
  logic              pop;
  logic              ctrl_wr;
  logic              flush;
  logic              clr_flags;
  logic              ovf_evt;
  logic              unf_evt;
  logic              overflow;
  logic              underflow;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [63:0]       rd_mux;
  t_mmio_fifo_status status;

  assign hit_data   = (bus.mmio_addr == ADDR_W'(BASE_ADDR + REG_DATA));
  assign hit_status = (bus.mmio_addr == ADDR_W'(BASE_ADDR + REG_STATUS));
  assign hit_ctrl   = (bus.mmio_addr == ADDR_W'(BASE_ADDR + REG_CTRL));
  assign hit_peek   = (bus.mmio_addr == ADDR_W'(BASE_ADDR + REG_PEEK));
  assign any_hit    = hit_data | hit_status | hit_ctrl | hit_peek;

  assign push      = bus.mmio_wr_valid & hit_data;
  assign pop       = bus.mmio_rd_valid & hit_data;
  assign ctrl_wr   = bus.mmio_wr_valid & hit_ctrl;
  assign flush     = ctrl_wr & bus.mmio_wr_data[CTRL_FLUSH_BIT];
  assign clr_flags = ctrl_wr & bus.mmio_wr_data[CTRL_CLR_FLAGS_BIT];

  assign ovf_evt = push & full & ~pop;
  assign unf_evt = pop & empty;

  sync_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (bus.mmio_wr_data[DATA_W-1:0]),
    .head    (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  // A new error event outranks a clear issued in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_flags) | ovf_evt;
      underflow <= (underflow & ~clr_flags) | unf_evt;
    end
  end

  always_comb begin
    status           = '0;
    status.count     = 16'(fifo_count);
    status.empty     = empty;
    status.full      = full;
    status.overflow  = overflow;
    status.underflow = underflow;
    status.depth     = 16'(DEPTH);
  end

  // Head reads are gated by the pre-cycle empty flag, so an empty FIFO always reads as zero.
  always_comb begin
    rd_mux = '0;
    if (hit_data || hit_peek) begin
      rd_mux = empty ? 64'h0 : 64'(head);
    end else if (hit_status) begin
      rd_mux = status;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_resp_valid <= 1'b0;
      bus.rd_resp_tid   <= '0;
      bus.rd_resp_data  <= '0;
    end else begin
      bus.rd_resp_valid <= bus.mmio_rd_valid & any_hit;
      if (bus.mmio_rd_valid && any_hit) begin
        bus.rd_resp_tid  <= bus.mmio_tid;
        bus.rd_resp_data <= rd_mux;
      end
    end
  end

endmodule
